// File: rtl/maze_pkg.sv
// Shared maze definitions: heading encodings, solver state enum and the
// turn lookup used by both the solver and the command processor.
package maze_pkg;

    localparam logic [11:0] HDNG_N = 12'h000;
    localparam logic [11:0] HDNG_W = 12'h3FF;
    localparam logic [11:0] HDNG_S = 12'h7FF;
    localparam logic [11:0] HDNG_E = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MV,
        ST_WAIT_MV,
        ST_SETTLE,
        ST_DECIDE,
        ST_HDNG,
        ST_WAIT_HDNG,
        ST_DONE
    } solve_state_t;

    typedef enum logic [1:0] {
        TURN_L,
        TURN_R,
        TURN_180
    } turn_t;

    // Any heading that is not one of the four encodings is treated as north.
    function automatic logic [11:0] turn_hdng(input logic [11:0] hdng, input turn_t turn);
        logic [11:0] lft;
        logic [11:0] rght;
        logic [11:0] back;
        case (hdng)
            HDNG_W: begin lft = HDNG_S; rght = HDNG_N; back = HDNG_E; end
            HDNG_S: begin lft = HDNG_E; rght = HDNG_W; back = HDNG_N; end
            HDNG_E: begin lft = HDNG_N; rght = HDNG_S; back = HDNG_W; end
            default: begin lft = HDNG_W; rght = HDNG_E; back = HDNG_S; end
        endcase
        case (turn)
            TURN_L:   return lft;
            TURN_R:   return rght;
            TURN_180: return back;
            default:  return hdng;
        endcase
    endfunction

endpackage

// File: rtl/maze_solve.sv
// Wall-follower maze solver: drives the navigator with forward moves and
// heading changes, choosing turns from the IR openings after each move.
module maze_solve
    import maze_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_md,
    input  logic        cmd0,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        mv_cmplt,
    input  logic        sol_cmplt,
    output logic        strt_hdng,
    output logic        strt_mv,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic [11:0] dsrd_hdng
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    solve_state_t state;
    logic [7:0]   settle_cnt;
    logic         aff_lft;
    logic         active;
    turn_t        turn_sel;

    // Preferred side first, then the other side, otherwise turn around.
    always_comb begin
        turn_sel = TURN_180;
        if (aff_lft) begin
            if (lft_opn)       turn_sel = TURN_L;
            else if (rght_opn) turn_sel = TURN_R;
        end else begin
            if (rght_opn)      turn_sel = TURN_R;
            else if (lft_opn)  turn_sel = TURN_L;
        end
    end

    assign active   = (state != ST_IDLE) && (state != ST_DONE);
    assign stp_lft  = active & aff_lft;
    assign stp_rght = active & ~aff_lft;

    // Start pulses are registered on leaving MV/HDNG, so an abort in those
    // states suppresses the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dsrd_hdng  <= HDNG_N;
            strt_hdng  <= 1'b0;
            strt_mv    <= 1'b0;
            settle_cnt <= 8'd0;
            aff_lft    <= 1'b1;
        end else begin
            strt_hdng <= 1'b0;
            strt_mv   <= 1'b0;
            if (cmd_md && state != ST_DONE) begin
                state <= ST_IDLE;
            end else if (sol_cmplt && state != ST_IDLE && state != ST_DONE) begin
                state <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        aff_lft <= cmd0;
                        state   <= ST_MV;
                    end
                    ST_MV: begin
                        strt_mv <= 1'b1;
                        state   <= ST_WAIT_MV;
                    end
                    ST_WAIT_MV: begin
                        if (mv_cmplt) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == 8'd0) state <= ST_DECIDE;
                        else                    settle_cnt <= settle_cnt - 8'd1;
                    end
                    ST_DECIDE: begin
                        dsrd_hdng <= turn_hdng(dsrd_hdng, turn_sel);
                        state     <= ST_HDNG;
                    end
                    ST_HDNG: begin
                        strt_hdng <= 1'b1;
                        state     <= ST_WAIT_HDNG;
                    end
                    ST_WAIT_HDNG: begin
                        if (mv_cmplt) state <= ST_MV;
                    end
                    ST_DONE: begin
                        if (cmd_md) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
